// File: rtl/tcm_obi_arbiter.sv
// Two-master OBI arbiter onto TCM port A: round-robin grant, window range check,
// and routing of the one-cycle-later response back to the owning master.
module tcm_obi_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
    parameter int unsigned MEM_SIZE  = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        m0_req_i,
    output logic        m0_gnt_o,
    input  logic [31:0] m0_addr_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,
    input  logic        m1_req_i,
    output logic        m1_gnt_o,
    input  logic [31:0] m1_addr_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,
    output logic        tcm_req_o,
    output logic        tcm_we_o,
    output logic [3:0]  tcm_be_o,
    output logic [31:0] tcm_addr_o,
    output logic [31:0] tcm_wdata_o,
    input  logic        tcm_rvalid_i,
    input  logic [31:0] tcm_rdata_i
);

    localparam logic [31:0] WINDOW_BYTES = 32'(4 * MEM_SIZE);

    typedef enum logic {
        MST0 = 1'b0,
        MST1 = 1'b1
    } master_e;

    master_e     prio_q;
    master_e     resp_owner_q;
    logic        resp_valid_q;
    logic        resp_err_q;

    logic        any_gnt;
    master_e     sel;
    logic [31:0] sel_addr;
    logic [31:0] off;
    logic        in_range;

    // The TCM response valid is implied by the fixed one-cycle latency.
    logic        unused_bits;
    assign unused_bits = ^{tcm_rvalid_i, off[1:0]};

    // Grant selection: single requester wins, otherwise the priority master.
    always_comb begin
        m0_gnt_o = 1'b0;
        m1_gnt_o = 1'b0;
        if (m0_req_i && m1_req_i) begin
            if (prio_q == MST0) begin
                m0_gnt_o = 1'b1;
            end else begin
                m1_gnt_o = 1'b1;
            end
        end else if (m0_req_i) begin
            m0_gnt_o = 1'b1;
        end else if (m1_req_i) begin
            m1_gnt_o = 1'b1;
        end else begin
            m0_gnt_o = 1'b0;
        end
    end

    assign any_gnt  = m0_gnt_o | m1_gnt_o;
    assign sel      = m1_gnt_o ? MST1 : MST0;
    assign sel_addr = m1_gnt_o ? m1_addr_i : m0_addr_i;
    // Unsigned wrap makes addresses below the base land far out of range.
    assign off      = sel_addr - BASE_ADDR;
    assign in_range = any_gnt && (off < WINDOW_BYTES);

    // TCM request path, zeroed whenever no access is forwarded.
    always_comb begin
        tcm_req_o   = 1'b0;
        tcm_we_o    = 1'b0;
        tcm_be_o    = 4'b0000;
        tcm_addr_o  = 32'h0000_0000;
        tcm_wdata_o = 32'h0000_0000;
        if (in_range) begin
            tcm_req_o   = 1'b1;
            tcm_addr_o  = {off[31:2], 2'b00};
            tcm_we_o    = (sel == MST1) ? m1_we_i    : m0_we_i;
            tcm_be_o    = (sel == MST1) ? m1_be_i    : m0_be_i;
            tcm_wdata_o = (sel == MST1) ? m1_wdata_i : m0_wdata_i;
        end else begin
            tcm_req_o = 1'b0;
        end
    end

    // Round-robin pointer and the pending-response record.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q       <= MST0;
            resp_valid_q <= 1'b0;
            resp_owner_q <= MST0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= any_gnt;
            resp_err_q   <= any_gnt && !in_range;
            if (any_gnt) begin
                prio_q       <= (sel == MST0) ? MST1 : MST0;
                resp_owner_q <= sel;
            end else begin
                prio_q       <= prio_q;
                resp_owner_q <= resp_owner_q;
            end
        end
    end

    // Response steering; error responses never expose TCM data.
    always_comb begin
        m0_rvalid_o = resp_valid_q && (resp_owner_q == MST0);
        m1_rvalid_o = resp_valid_q && (resp_owner_q == MST1);
        m0_err_o    = m0_rvalid_o && resp_err_q;
        m1_err_o    = m1_rvalid_o && resp_err_q;
        m0_rdata_o  = (m0_rvalid_o && !resp_err_q) ? tcm_rdata_i : 32'h0000_0000;
        m1_rdata_o  = (m1_rvalid_o && !resp_err_q) ? tcm_rdata_i : 32'h0000_0000;
    end

endmodule

// File: tb/tb_tcm_obi_arbiter.sv
// Table-driven bench for tcm_obi_arbiter with a response scoreboard and a
// one-cycle-latency TCM model.
module tb_tcm_obi_arbiter;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        m0_req, m0_gnt, m0_we, m0_rvalid, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_be;
    logic        m1_req, m1_gnt, m1_we, m1_rvalid, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_be;
    logic        tcm_req, tcm_we, tcm_rvalid;
    logic [3:0]  tcm_be;
    logic [31:0] tcm_addr, tcm_wdata, tcm_rdata;
    logic [31:0] cur_rd = 32'h0000_0000;
    logic        spur = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        r0;
        logic [31:0] a0;
        logic        we0;
        logic [3:0]  be0;
        logic        r1;
        logic [31:0] a1;
        logic        we1;
        logic [3:0]  be1;
        logic [31:0] rd;
        logic        eg0;
        logic        eg1;
        logic        etreq;
        logic [31:0] etaddr;
    } vec_t;

    typedef struct {
        logic        valid;
        logic        owner;
        logic        err;
        logic [31:0] rd;
    } resp_t;

    resp_t sb[$];
    vec_t  tab[15];

    tcm_obi_arbiter dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
        .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_rvalid_o(m0_rvalid),
        .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
        .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
        .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_rvalid_o(m1_rvalid),
        .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
        .tcm_req_o(tcm_req), .tcm_we_o(tcm_we), .tcm_be_o(tcm_be), .tcm_addr_o(tcm_addr),
        .tcm_wdata_o(tcm_wdata), .tcm_rvalid_i(tcm_rvalid), .tcm_rdata_i(tcm_rdata)
    );

    always #5 clk = ~clk;

    // TCM model: answers one cycle after a request with the data chosen by the vector.
    always @(posedge clk) begin
        tcm_rvalid <= tcm_req | spur;
        tcm_rdata  <= tcm_req ? cur_rd : 32'hBAD0_BAD0;
    end

    function automatic vec_t mk(input logic r0, input logic [31:0] a0, input logic we0,
                                input logic [3:0] be0, input logic r1, input logic [31:0] a1,
                                input logic we1, input logic [3:0] be1, input logic [31:0] rd,
                                input logic eg0, input logic eg1, input logic etreq,
                                input logic [31:0] etaddr);
        vec_t v;
        v.r0 = r0; v.a0 = a0; v.we0 = we0; v.be0 = be0;
        v.r1 = r1; v.a1 = a1; v.we1 = we1; v.be1 = be1;
        v.rd = rd; v.eg0 = eg0; v.eg1 = eg1; v.etreq = etreq; v.etaddr = etaddr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        m0_req = 1'b0; m0_addr = 32'h0; m0_we = 1'b0; m0_be = 4'h0; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_addr = 32'h0; m1_we = 1'b0; m1_be = 4'h0; m1_wdata = 32'h0;
    endtask

    task automatic check_resp();
        resp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("m0_rvalid", {31'd0, m0_rvalid}, {31'd0, e.valid && !e.owner});
            chk("m1_rvalid", {31'd0, m1_rvalid}, {31'd0, e.valid && e.owner});
            chk("m0_err", {31'd0, m0_err}, {31'd0, e.valid && !e.owner && e.err});
            chk("m1_err", {31'd0, m1_err}, {31'd0, e.valid && e.owner && e.err});
            chk("m0_rdata", m0_rdata, (e.valid && !e.owner && !e.err) ? e.rd : 32'h0);
            chk("m1_rdata", m1_rdata, (e.valid && e.owner && !e.err) ? e.rd : 32'h0);
        end
    endtask

    task automatic drive_vec(input vec_t v);
        resp_t       e;
        logic [31:0] exp_wd;
        logic        exp_we;
        logic [3:0]  exp_be;
        @(negedge clk);
        check_resp();
        m0_req = v.r0; m0_addr = v.a0; m0_we = v.we0; m0_be = v.be0;
        m0_wdata = v.a0 ^ 32'h5555_5555;
        m1_req = v.r1; m1_addr = v.a1; m1_we = v.we1; m1_be = v.be1;
        m1_wdata = v.a1 ^ 32'hAAAA_AAAA;
        cur_rd = v.rd;
        exp_wd = !v.etreq ? 32'h0 : (v.eg1 ? (v.a1 ^ 32'hAAAA_AAAA) : (v.a0 ^ 32'h5555_5555));
        exp_we = v.etreq && (v.eg1 ? v.we1 : v.we0);
        exp_be = !v.etreq ? 4'h0 : (v.eg1 ? v.be1 : v.be0);
        #1;
        chk("m0_gnt", {31'd0, m0_gnt}, {31'd0, v.eg0});
        chk("m1_gnt", {31'd0, m1_gnt}, {31'd0, v.eg1});
        chk("tcm_req", {31'd0, tcm_req}, {31'd0, v.etreq});
        chk("tcm_addr", tcm_addr, v.etreq ? v.etaddr : 32'h0);
        chk("tcm_be", {28'd0, tcm_be}, {28'd0, exp_be});
        chk("tcm_we", {31'd0, tcm_we}, {31'd0, exp_we});
        chk("tcm_wdata", tcm_wdata, exp_wd);
        e.valid = v.eg0 | v.eg1;
        e.owner = v.eg1;
        e.err   = (v.eg0 | v.eg1) && !v.etreq;
        e.rd    = v.rd;
        sb.push_back(e);
    endtask

    initial begin
        set_idle();
        //            r0    a0              we0   be0      r1    a1              we1   be1      rd              eg0   eg1   treq  taddr
        tab[0]  = mk(1'b0, 32'h0000_0000, 1'b0, 4'h0,   1'b1, 32'h0001_1000, 1'b1, 4'hF,   32'h1111_1111, 1'b0, 1'b1, 1'b0, 32'h0);
        tab[1]  = mk(1'b1, 32'h0001_0100, 1'b0, 4'hF,   1'b1, 32'h0001_0200, 1'b1, 4'hC,   32'h2222_0001, 1'b1, 1'b0, 1'b1, 32'h100);
        tab[2]  = mk(1'b1, 32'h0001_0104, 1'b0, 4'hF,   1'b1, 32'h0001_0204, 1'b1, 4'hC,   32'h2222_0002, 1'b0, 1'b1, 1'b1, 32'h204);
        tab[3]  = mk(1'b1, 32'h0001_0108, 1'b0, 4'hF,   1'b1, 32'h0001_0208, 1'b1, 4'hC,   32'h2222_0003, 1'b1, 1'b0, 1'b1, 32'h108);
        tab[4]  = mk(1'b1, 32'h0001_010C, 1'b0, 4'hF,   1'b1, 32'h0001_020C, 1'b1, 4'hC,   32'h2222_0004, 1'b0, 1'b1, 1'b1, 32'h20C);
        tab[5]  = mk(1'b1, 32'h0001_0010, 1'b0, 4'hF,   1'b0, 32'h0000_0000, 1'b0, 4'h0,   32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 32'h10);
        tab[6]  = mk(1'b1, 32'h0000_FFFC, 1'b0, 4'hF,   1'b0, 32'h0000_0000, 1'b0, 4'h0,   32'h3333_3333, 1'b1, 1'b0, 1'b0, 32'h0);
        tab[7]  = mk(1'b1, 32'h0001_0004, 1'b1, 4'h3,   1'b0, 32'h0000_0000, 1'b0, 4'h0,   32'h4444_4444, 1'b1, 1'b0, 1'b1, 32'h4);
        tab[8]  = mk(1'b1, 32'h0001_0004, 1'b0, 4'hF,   1'b0, 32'h0000_0000, 1'b0, 4'h0,   32'h5555_0004, 1'b1, 1'b0, 1'b1, 32'h4);
        tab[9]  = mk(1'b0, 32'h0000_0000, 1'b0, 4'h0,   1'b0, 32'h0000_0000, 1'b0, 4'h0,   32'h6666_6666, 1'b0, 1'b0, 1'b0, 32'h0);
        tab[10] = mk(1'b0, 32'h0000_0000, 1'b0, 4'h0,   1'b1, 32'h0001_0FFC, 1'b0, 4'hF,   32'h7777_0FFC, 1'b0, 1'b1, 1'b1, 32'hFFC);
        tab[11] = mk(1'b1, 32'h0001_0013, 1'b0, 4'h8,   1'b0, 32'h0000_0000, 1'b0, 4'h0,   32'h8888_0013, 1'b1, 1'b0, 1'b1, 32'h10);
        tab[12] = mk(1'b0, 32'h0000_0000, 1'b0, 4'h0,   1'b1, 32'h0001_0FFF, 1'b1, 4'h8,   32'h9999_0FFF, 1'b0, 1'b1, 1'b1, 32'hFFC);
        tab[13] = mk(1'b1, 32'h0002_0000, 1'b0, 4'hF,   1'b1, 32'h0001_0000, 1'b0, 4'hF,   32'hAAAA_0000, 1'b1, 1'b0, 1'b0, 32'h0);
        tab[14] = mk(1'b0, 32'h0000_0000, 1'b0, 4'h0,   1'b1, 32'h0001_0000, 1'b0, 4'hF,   32'hBBBB_0000, 1'b0, 1'b1, 1'b1, 32'h0);

        // Reset state with no requests.
        repeat (2) @(negedge clk);
        chk("rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
        chk("rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
        chk("rst_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
        chk("rst_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
        chk("rst_m0_err", {31'd0, m0_err}, 32'd0);
        chk("rst_m1_err", {31'd0, m1_err}, 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_m1_rdata", m1_rdata, 32'h0);
        chk("rst_tcm_req", {31'd0, tcm_req}, 32'd0);
        rst_ni = 1'b1;

        // The first entry only seeds the scoreboard with an empty slot.
        begin
            resp_t idle_e;
            idle_e.valid = 1'b0; idle_e.owner = 1'b0; idle_e.err = 1'b0; idle_e.rd = 32'h0;
            sb.push_back(idle_e);
        end
        for (int i = 0; i < 15; i++) begin
            drive_vec(tab[i]);
        end
        @(negedge clk);
        check_resp();
        set_idle();
        chk("sb_empty", sb.size(), 32'd0);

        // Spurious TCM rvalid with nothing pending must not leak.
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        @(negedge clk);
        chk("spur_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
        chk("spur_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
        chk("spur_m0_rdata", m0_rdata, 32'h0);
        chk("spur_m1_rdata", m1_rdata, 32'h0);

        // Reset between accept and response drops the response and restores priority.
        m0_req = 1'b1; m0_addr = 32'h0001_0040; m0_be = 4'hF; cur_rd = 32'hC0DE_0040;
        #1;
        chk("pre_rst_gnt", {31'd0, m0_gnt}, 32'd1);
        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        set_idle();
        @(negedge clk);
        chk("rst_drop_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
        chk("rst_drop_m0_rdata", m0_rdata, 32'h0);
        @(negedge clk);
        chk("rst_hold_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
        rst_ni = 1'b1;
        m0_req = 1'b1; m0_addr = 32'h0001_0050; m0_be = 4'hF;
        m1_req = 1'b1; m1_addr = 32'h0001_0060; m1_be = 4'hF;
        cur_rd = 32'hC0DE_0050;
        #1;
        chk("post_rst_m0_gnt", {31'd0, m0_gnt}, 32'd1);
        chk("post_rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
        chk("post_rst_addr", tcm_addr, 32'h50);
        @(negedge clk);
        set_idle();
        chk("post_rst_m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
        chk("post_rst_m0_rdata", m0_rdata, 32'hC0DE_0050);
        chk("post_rst_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
